// File: rtl/mem_responder.sv
// Target side of the CPU memory bus: 256x16 data RAM plus memory-mapped LED and switch registers,
// with registered read data, a sticky illegal-access flag and a saturating transaction counter.
module mem_responder #(
  parameter int unsigned RAM_DEPTH = 256,
  parameter logic [8:0]  LED_ADDR  = 9'h100,
  parameter logic [8:0]  SW_ADDR   = 9'h140
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mem_cmd,
  input  logic [8:0]  mem_addr,
  input  logic [15:0] write_data,
  output logic [15:0] read_data,
  output logic        rd_valid,
  input  logic [7:0]  sw,
  output logic [7:0]  led,
  output logic        bus_err,
  output logic [15:0] access_count
);

  typedef enum logic [1:0] {StIdle, StRd, StWr} state_e;

  logic [15:0] ram_q [RAM_DEPTH];

  state_e      state_q, state_d;
  logic [8:0]  last_addr_q, last_addr_d;
  logic [15:0] read_data_q, read_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic [7:0]  led_q, led_d;
  logic        bus_err_q, bus_err_d;
  logic [15:0] count_q, count_d;
  logic [7:0]  sw_meta_q, sw_sync_q;

  logic is_rd, is_wr, cmd_err;
  logic sel_ram, sel_led, sel_sw, unmapped;
  logic ram_we, new_txn;

  always_comb begin
    is_rd   = 1'b0;
    is_wr   = 1'b0;
    cmd_err = 1'b0;
    // Anything that is not an exact read/write/illegal code (including X/Z) is treated as idle.
    case (mem_cmd)
      2'b01:   is_rd   = 1'b1;
      2'b10:   is_wr   = 1'b1;
      2'b11:   cmd_err = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    sel_ram  = ~mem_addr[8];
    sel_led  = (mem_addr == LED_ADDR);
    sel_sw   = (mem_addr == SW_ADDR);
    unmapped = mem_addr[8] & ~sel_led & ~sel_sw;
  end

  always_comb begin
    read_data_d = read_data_q;
    rd_valid_d  = is_rd;
    led_d       = led_q;
    ram_we      = is_wr & sel_ram;
    bus_err_d   = bus_err_q | cmd_err | ((is_rd | is_wr) & unmapped);

    if (is_rd) begin
      if (sel_ram) begin
        read_data_d = ram_q[mem_addr[7:0]];
      end else if (sel_led) begin
        read_data_d = {8'h00, led_q};
      end else if (sel_sw) begin
        read_data_d = {8'h00, sw_sync_q};
      end else begin
        read_data_d = 16'h0000;
      end
    end
    if (is_wr && sel_led) begin
      led_d = write_data[7:0];
    end
  end

  always_comb begin
    state_d     = StIdle;
    last_addr_d = mem_addr;
    if (is_rd) begin
      state_d = StRd;
    end else if (is_wr) begin
      state_d = StWr;
    end
    // A held read/write on the same address is one transaction; a change of kind or address is new.
    new_txn = (state_d != StIdle) && ((state_d != state_q) || (mem_addr != last_addr_q));
    count_d = (new_txn && (count_q != 16'hFFFF)) ? count_q + 16'd1 : count_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      last_addr_q <= 9'h000;
      read_data_q <= 16'h0000;
      rd_valid_q  <= 1'b0;
      led_q       <= 8'h00;
      bus_err_q   <= 1'b0;
      count_q     <= 16'h0000;
      sw_meta_q   <= 8'h00;
      sw_sync_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      last_addr_q <= last_addr_d;
      read_data_q <= read_data_d;
      rd_valid_q  <= rd_valid_d;
      led_q       <= led_d;
      bus_err_q   <= bus_err_d;
      count_q     <= count_d;
      sw_meta_q   <= sw;
      sw_sync_q   <= sw_meta_q;
    end
  end

  // RAM is not cleared by reset; an edge taken while reset is low must not write.
  always_ff @(posedge clk or negedge reset) begin
    if (reset && ram_we) begin
      ram_q[mem_addr[7:0]] <= write_data;
    end
  end

  assign read_data    = read_data_q;
  assign rd_valid     = rd_valid_q;
  assign led          = led_q;
  assign bus_err      = bus_err_q;
  assign access_count = count_q;

endmodule
